// File: rtl/dcache_assoc.sv
// Two-way set-associative, write-back, write-allocate data cache with per-set LRU
// replacement and a halt-triggered flush that finishes by storing the hit count.
`timescale 1ns/1ps
module dcache_assoc #(
    parameter int unsigned SETS    = 8,
    parameter int unsigned WORDS   = 2,
    parameter logic [31:0] HITADDR = 32'h0000_3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic [31:0] dmemload,
    output logic        dhit,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    localparam int unsigned WOB = $clog2(WORDS);
    localparam int unsigned IXB = $clog2(SETS);
    localparam int unsigned TGB = 30 - WOB - IXB;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WB    = 3'd1;
    localparam logic [2:0] FILL  = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] CNT   = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]     r_state;
    logic [WOB-1:0] r_cnt;
    logic [IXB-1:0] r_fset;
    logic           r_fway;
    logic           r_victim;
    logic           r_missed;
    logic [31:0]    r_hitcnt;
    logic [TGB-1:0] r_mtag;
    logic [IXB-1:0] r_midx;
    logic [SETS-1:0] r_lru;
    logic [1:0]     r_valid [SETS];
    logic [1:0]     r_dirty [SETS];
    logic [TGB-1:0] r_tag   [SETS][2];
    logic [31:0]    r_data  [SETS][2][WORDS];

    logic [WOB-1:0] w_woff;
    logic [IXB-1:0] w_idx;
    logic [TGB-1:0] w_tag;
    logic           w_hit0, w_hit1, w_hitway, w_req, w_dhit, w_dowrite;
    logic           w_victim, w_last, w_flast, w_fdirty;
    logic           w_unused_bits;

    assign w_woff        = dmemaddr[2 +: WOB];
    assign w_idx         = dmemaddr[2 + WOB +: IXB];
    assign w_tag         = dmemaddr[31 -: TGB];
    assign w_unused_bits = ^dmemaddr[1:0];

    assign w_hit0    = r_valid[w_idx][0] && (r_tag[w_idx][0] == w_tag);
    assign w_hit1    = r_valid[w_idx][1] && (r_tag[w_idx][1] == w_tag);
    assign w_hitway  = !w_hit0;
    assign w_req     = dmemREN || dmemWEN;
    assign w_dhit    = (r_state == IDLE) && !halt && w_req && (w_hit0 || w_hit1);
    assign w_dowrite = w_dhit && !dmemREN;
    assign w_victim  = !r_valid[w_idx][0] ? 1'b0 :
                       !r_valid[w_idx][1] ? 1'b1 : r_lru[w_idx];
    assign w_last    = (r_cnt == WOB'(WORDS - 1));
    assign w_flast   = (r_fset == IXB'(SETS - 1)) && r_fway;
    assign w_fdirty  = r_valid[r_fset][r_fway] && r_dirty[r_fset][r_fway];

    always_comb begin
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        flushed  = 1'b0;
        dhit     = w_dhit;
        dmemload = (w_dhit && dmemREN) ? r_data[w_idx][w_hitway][w_woff] : '0;
        case (r_state)
            WB: begin
                dWEN   = 1'b1;
                daddr  = {r_tag[r_midx][r_victim], r_midx, r_cnt, 2'b00};
                dstore = r_data[r_midx][r_victim][r_cnt];
            end
            FILL: begin
                dREN  = 1'b1;
                daddr = {r_mtag, r_midx, r_cnt, 2'b00};
            end
            FLUSH: begin
                if (w_fdirty) begin
                    dWEN   = 1'b1;
                    daddr  = {r_tag[r_fset][r_fway], r_fset, r_cnt, 2'b00};
                    dstore = r_data[r_fset][r_fway][r_cnt];
                end
            end
            CNT: begin
                dWEN   = 1'b1;
                daddr  = HITADDR;
                dstore = r_hitcnt;
            end
            DONE:    flushed = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_fset   <= '0;
            r_fway   <= 1'b0;
            r_victim <= 1'b0;
            r_missed <= 1'b0;
            r_hitcnt <= '0;
            r_mtag   <= '0;
            r_midx   <= '0;
            r_lru    <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (halt) begin
                        r_state <= FLUSH;
                        r_fset  <= '0;
                        r_fway  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_dhit) begin
                        r_lru[w_idx] <= ~w_hitway;
                        r_missed     <= 1'b0;
                        if (!r_missed)
                            r_hitcnt <= r_hitcnt + 32'd1;
                        if (w_dowrite)
                            r_dirty[w_idx][w_hitway] <= 1'b1;
                    end else if (w_req) begin
                        r_victim <= w_victim;
                        r_mtag   <= w_tag;
                        r_midx   <= w_idx;
                        r_missed <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) ? WB : FILL;
                    end
                end
                WB: begin
                    if (!dwait) begin
                        r_cnt <= r_cnt + WOB'(1);
                        if (w_last)
                            r_state <= FILL;
                    end
                end
                FILL: begin
                    if (!dwait) begin
                        r_cnt <= r_cnt + WOB'(1);
                        if (w_last) begin
                            r_valid[r_midx][r_victim] <= 1'b1;
                            r_dirty[r_midx][r_victim] <= 1'b0;
                            r_state                   <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    // Clean or invalid lines cost one cycle; dirty ones stay until every word is written.
                    if (!w_fdirty || (!dwait && w_last)) begin
                        if (w_fdirty)
                            r_dirty[r_fset][r_fway] <= 1'b0;
                        if (w_flast)
                            r_state <= CNT;
                        else
                            {r_fset, r_fway} <= {r_fset, r_fway} + (IXB + 1)'(1);
                    end
                    if (w_fdirty && !dwait)
                        r_cnt <= r_cnt + WOB'(1);
                end
                CNT: begin
                    if (!dwait)
                        r_state <= DONE;
                end
                DONE:    ;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_dowrite)
            r_data[w_idx][w_hitway][w_woff] <= dmemstore;
        if (r_state == FILL && !dwait) begin
            r_data[r_midx][r_victim][r_cnt] <= dload;
            if (w_last)
                r_tag[r_midx][r_victim] <= r_mtag;
        end
    end

endmodule

// File: tb/tb_dcache_assoc.sv
// Scoreboard bench for dcache_assoc: expected bus transfers and read data are queued
// with the stimulus and compared when the cache produces them.
`timescale 1ns/1ps
module tb_dcache_assoc;
    logic        CLK = 1'b0;
    logic        nRST, halt, dmemREN, dmemWEN, dwait;
    logic [31:0] dmemaddr, dmemstore, dmemload, daddr, dstore, dload;
    logic        dhit, flushed, dREN, dWEN;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    bus_t        exp_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] mem [4096];
    logic [31:0] mdl [4096];
    bus_t        mon_e;
    logic [31:0] mon_d;
    int          checks = 0;
    int          errors = 0;
    int          exp_hits = 0;

    always #10 CLK = ~CLK;

    dcache_assoc #(.SETS(8), .WORDS(2), .HITADDR(32'h0000_3100)) dut (
        .CLK(CLK), .nRST(nRST), .halt(halt),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dmemload(dmemload), .dhit(dhit), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait)
    );

    assign dload = mem[daddr[13:2]];

    // Bus and read-data monitor, sampled mid-cycle after the drivers have settled.
    always @(negedge CLK) begin
        #2;
        if (nRST) begin
            if ((dREN || dWEN) && !dwait) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_extra: got %s addr=%h data=%h, required no transfer",
                             dWEN ? "W" : "R", daddr, dstore);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (dREN === dWEN || dWEN !== mon_e.wr || daddr !== mon_e.addr ||
                        (mon_e.wr && dstore !== mon_e.data)) begin
                        errors++;
                        $display("FAIL bus_xfer: got ren=%b wen=%b addr=%h data=%h, required %s addr=%h data=%h",
                                 dREN, dWEN, daddr, dstore, mon_e.wr ? "W" : "R", mon_e.addr, mon_e.data);
                    end
                end
                if (dWEN) mem[daddr[13:2]] = dstore;
            end
            if (dhit && dmemREN) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL read_extra: got dmemload=%h, required no read hit", dmemload);
                end else begin
                    mon_d = rd_q.pop_front();
                    if (dmemload !== mon_d) begin
                        errors++;
                        $display("FAIL read_data: addr=%h got %h, required %h", dmemaddr, dmemload, mon_d);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic push_bus(input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus_t e;
        e.wr = wr; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_fill(input logic [31:0] base);
        push_bus(1'b0, base, '0);
        push_bus(1'b0, base + 32'd4, '0);
    endtask

    task automatic do_req(input logic rd, input logic [31:0] a, input logic [31:0] wd, output int lat);
        @(negedge CLK);
        dmemREN = rd; dmemWEN = !rd; dmemaddr = a; dmemstore = wd;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (dhit) begin lat = i; break; end
            @(negedge CLK);
        end
        @(negedge CLK);
        dmemREN = 1'b0; dmemWEN = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output int lat);
        rd_q.push_back(mdl[a[13:2]]);
        do_req(1'b1, a, '0, lat);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, output int lat);
        do_req(1'b0, a, d, lat);
        mdl[a[13:2]] = d;
    endtask

    task automatic test_reset;
        nRST = 1'b0; halt = 1'b0; dmemWEN = 1'b0; dwait = 1'b0;
        dmemREN = 1'b1; dmemaddr = 32'h40; dmemstore = '0;
        #15;
        checks++;
        if ({dREN, dWEN, daddr, dstore, dhit, dmemload, flushed} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ren=%b wen=%b addr=%h st=%h hit=%b ld=%h fl=%b, required all 0",
                     dREN, dWEN, daddr, dstore, dhit, dmemload, flushed);
        end
        @(negedge CLK);
        nRST = 1'b1; dmemREN = 1'b0;
    endtask

    task automatic test_cold_read;
        int lat;
        push_fill(32'h40);
        rd(32'h40, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL cold_read_latency: got %0d, required 3", lat); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL cold_read_bus: %0d transfers missing, required 0", exp_q.size()); end
    endtask

    task automatic test_write_hit;
        int lat;
        wr(32'h44, 32'h0000_DEAD, lat);
        exp_hits++;
        checks++;
        if (lat !== 0) begin errors++; $display("FAIL write_hit_latency: got %0d, required 0", lat); end
        rd(32'h44, lat);
        exp_hits++;
        checks++;
        if (lat !== 0) begin errors++; $display("FAIL read_after_write_latency: got %0d, required 0", lat); end
    endtask

    task automatic test_lru;
        int lat;
        int exp_lat [5] = '{0, 3, 0, 3, 0};
        logic [31:0] addrs [5] = '{32'h40, 32'h80, 32'h40, 32'hC0, 32'h40};
        for (int i = 0; i < 5; i++) begin
            if (exp_lat[i] != 0) push_fill(addrs[i]);
            else exp_hits++;
            rd(addrs[i], lat);
            checks++;
            if (lat !== exp_lat[i]) begin
                errors++;
                $display("FAIL lru_latency[%0d]: addr=%h got %0d, required %0d", i, addrs[i], lat, exp_lat[i]);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL lru_bus: %0d transfers missing, required 0", exp_q.size()); end
    endtask

    task automatic test_dirty_victim;
        int lat;
        wr(32'h40, 32'h1234_5678, lat);
        exp_hits++;
        checks++;
        if (lat !== 0) begin errors++; $display("FAIL dirty_write_latency: got %0d, required 0", lat); end
        push_fill(32'h80);
        rd(32'h80, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL dirty_read80_latency: got %0d, required 3", lat); end
        push_bus(1'b1, 32'h40, mdl[32'h40 >> 2]);
        push_bus(1'b1, 32'h44, mdl[32'h44 >> 2]);
        push_fill(32'hC0);
        rd(32'hC0, lat);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL dirty_evict_latency: got %0d, required 5", lat); end
        push_fill(32'h40);
        rd(32'h40, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL dirty_refetch_latency: got %0d, required 3", lat); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL dirty_bus: %0d transfers missing, required 0", exp_q.size()); end
    endtask

    task automatic test_stall;
        int lat;
        push_fill(32'h148);
        rd_q.push_back(mdl[32'h148 >> 2]);
        @(negedge CLK);
        dmemREN = 1'b1; dmemaddr = 32'h148; dwait = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            #1;
            checks++;
            if (dREN !== 1'b1 || dWEN !== 1'b0 || daddr !== 32'h148) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got ren=%b wen=%b addr=%h, required ren=1 wen=0 addr=00000148",
                         k, dREN, dWEN, daddr);
            end
        end
        @(negedge CLK);
        dwait = 1'b0;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (dhit) begin lat = i; break; end
            @(negedge CLK);
        end
        @(negedge CLK);
        dmemREN = 1'b0;
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL stall_release_latency: got %0d, required 2", lat); end
    endtask

    task automatic test_halt_flush;
        int lat;
        int got;
        push_fill(32'h18);
        wr(32'h18, 32'hAAAA_0001, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL write_miss_latency: got %0d, required 3", lat); end
        wr(32'hC4, 32'hBBBB_0002, lat);
        exp_hits++;
        checks++;
        if (lat !== 0) begin errors++; $display("FAIL write_c4_latency: got %0d, required 0", lat); end
        push_bus(1'b1, 32'hC0, mdl[32'hC0 >> 2]);
        push_bus(1'b1, 32'hC4, mdl[32'hC4 >> 2]);
        push_bus(1'b1, 32'h18, mdl[32'h18 >> 2]);
        push_bus(1'b1, 32'h1C, mdl[32'h1C >> 2]);
        push_bus(1'b1, 32'h3100, 32'(exp_hits));
        @(negedge CLK);
        halt = 1'b1;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            #1;
            if (flushed) begin got = 1; break; end
        end
        checks++;
        if (got !== 1) begin errors++; $display("FAIL flush_done: flushed got 0 after 200 cycles, required 1"); end
        dmemREN = 1'b1; dmemaddr = 32'hC0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            #1;
            checks++;
            if (flushed !== 1'b1 || dhit !== 1'b0 || dmemload !== '0) begin
                errors++;
                $display("FAIL done_hold[%0d]: got flushed=%b dhit=%b ld=%h, required 1 0 00000000",
                         k, flushed, dhit, dmemload);
            end
        end
        dmemREN = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL flush_bus: %0d transfers missing, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_fill;
        int lat;
        int got;
        @(negedge CLK);
        nRST = 1'b0; halt = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        exp_hits = 0;
        push_fill(32'h40);
        rd_q.push_back(mdl[32'h40 >> 2]);
        @(negedge CLK);
        dmemREN = 1'b1; dmemaddr = 32'h40; dwait = 1'b0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            #1;
            if (dREN && daddr == 32'h44) begin dwait = 1'b1; got = 1; break; end
        end
        checks++;
        if (got !== 1) begin errors++; $display("FAIL mid_fill_reach: word 1 fetch not seen, required within 20 cycles"); end
        #3;
        nRST = 1'b0;
        #1;
        checks++;
        if ({dREN, dWEN, daddr, dstore, dhit, dmemload, flushed} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got ren=%b wen=%b addr=%h st=%h hit=%b ld=%h fl=%b, required all 0",
                     dREN, dWEN, daddr, dstore, dhit, dmemload, flushed);
        end
        checks++;
        if (exp_q.size() != 1) begin errors++; $display("FAIL mid_reset_pending: got %0d outstanding, required 1", exp_q.size()); end
        exp_q.delete();
        rd_q.delete();
        push_fill(32'h40);
        rd_q.push_back(mdl[32'h40 >> 2]);
        @(negedge CLK);
        nRST = 1'b1; dwait = 1'b0;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (dhit) begin lat = i; break; end
            @(negedge CLK);
        end
        @(negedge CLK);
        dmemREN = 1'b0;
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL refill_latency: got %0d, required 3", lat); end
        push_bus(1'b1, 32'h3100, 32'(exp_hits));
        halt = 1'b1;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            #1;
            if (flushed) begin got = 1; break; end
        end
        checks++;
        if (got !== 1) begin errors++; $display("FAIL reflush_done: flushed got 0 after 200 cycles, required 1"); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL reflush_bus: %0d transfers missing, required 0", exp_q.size()); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 32'h5A5A_0000 ^ 32'(i * 4);
            mdl[i] = 32'h5A5A_0000 ^ 32'(i * 4);
        end
        test_reset;
        test_cold_read;
        test_write_hit;
        test_lru;
        test_dirty_victim;
        test_stall;
        test_halt_flush;
        test_reset_mid_fill;
        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_assoc.md
Name: dcache_assoc

Overview:
- Parametrised two-way set-associative, write-back, write-allocate data cache between the datapath and the memory controller.
- Successor to the fixed 8-set, 2-word dcache; set count and block size are generalised.
- Adds true per-set LRU replacement and a complete halt flush with a hit-count writeback.
- Ports are flattened datapath and cache-control signals, so the block instantiates under any parameter set.

Parameters:
- SETS, 8, number of sets; power of 2, >=2.
- WORDS, 2, 32-bit words per block; power of 2, >=2.
- HITADDR, 32'h0000_3100, byte address that receives the hit count after the flush.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- halt  in  1  datapath halted; request flush.
- dmemREN  in  1  datapath read request.
- dmemWEN  in  1  datapath write request.
- dmemaddr  in  32  datapath byte address, word aligned.
- dmemstore  in  32  datapath write data.
- dmemload  out  32  read data; valid when dhit=1.
- dhit  out  1  request satisfied this cycle.
- flushed  out  1  flush and count write complete.
- dREN  out  1  memory read request.
- dWEN  out  1  memory write request.
- daddr  out  32  memory byte address.
- dstore  out  32  memory write data.
- dload  in  32  memory read data; valid when dwait=0.
- dwait  in  1  memory busy; a transfer completes in the cycle dwait=0.

Behaviour:
- Address fields:
  - [1:0] byte offset, ignored.
  - Next log2(WORDS) bits: word offset.
  - Next log2(SETS) bits: index.
  - Remaining bits: tag.
- Storage per set: per way valid, dirty, tag and WORDS data words; one LRU bit per set giving the way to evict.
- Reset (asynchronous, also mid-operation):
  - All valid, dirty and LRU bits are 0; hit counter is 0; state is IDLE.
  - All outputs are 0 immediately; any bus transaction in progress is abandoned.
- States: IDLE, WB, FILL, FLUSH, CNT, DONE. A word counter (log2(WORDS) bits) and a flush pointer (set plus way) persist across states.
- IDLE:
  - halt=1 has priority and goes to FLUSH.
  - dmemREN has priority over dmemWEN; both asserted together is treated as a read.
  - Hit is a valid way with a matching tag. On a hit, dhit=1 combinationally in the same cycle and LRU[idx] is set to the other way.
  - Read hit: dmemload is the addressed word.
  - Write hit: the word is written and dirty is set at the clock edge.
  - Miss with request: victim is the first invalid way (way0 first), otherwise way LRU[idx]. Go to WB if the victim is valid and dirty, else to FILL. Set the missed flag.
  - dmemload=0 whenever dhit=0.
- WB:
  - Drive dWEN=1, daddr={victim tag, idx, word counter, 2'b00}, dstore=the victim's word at the counter.
  - Each cycle with dwait=0, the counter increments.
  - After word WORDS-1, clear the counter and go to FILL.
- FILL:
  - Drive dREN=1, daddr={request tag, idx, word counter, 2'b00}.
  - Each cycle with dwait=0, dload is written into the victim's word at the counter.
  - On the last word, set valid=1, dirty=0 and tag, then return to IDLE. The request hits there one cycle later.
- Hit counter (32 bits):
  - Increments on dhit=1 in IDLE only while the missed flag is 0.
  - The missed flag clears on any dhit. Post-fill hits are therefore not counted.
- FLUSH:
  - Walks set 0..SETS-1, way0 then way1.
  - A line that is not valid and dirty is skipped in one cycle.
  - A dirty line is written back as in WB, then its dirty bit is cleared.
  - After set SETS-1 way1, go to CNT.
- CNT: drive dWEN=1, daddr=HITADDR, dstore=hit counter; go to DONE on dwait=0.
- DONE:
  - flushed=1 is held until reset.
  - dhit=0 and requests are ignored.
- halt asserted during WB or FILL: the miss completes first, then the flush is taken from IDLE.
- dwait held high: the block stalls indefinitely with the bus outputs held stable.

Test Plan:
- Cold read 0x40 (idx0, tag1) with dwait low for one cycle per word -> dREN to 0x40 then 0x44, then dhit=1 in IDLE with dmemload=mem[0x40]; counter stays 0.
- Write 0x44=0xDEAD after the fill, then read 0x44 -> dhit=1 on each in the same cycle, dmemload=0xDEAD; counter=2; line dirty.
- Reads 0x40, 0x80, then 0x40 again, then 0xC0 (all idx0) -> 0x80 occupies way1; 0xC0 evicts 0x80 (LRU), not 0x40. 0x40 rehit gives dhit=1 with no bus activity.
- Dirty victim: write 0x40, read 0x80, read 0xC0 -> dWEN to 0x40 and 0x44 with the written data precedes dREN to 0xC0 and 0xC4.
- halt with two dirty lines (sets 0 and 3) -> exactly four word writes in set order, then dWEN to 0x3100 with the hit count, then flushed=1 held; no other bus activity.
- nRST low during FILL word 1 -> all outputs 0 at once. After release, the same read misses again with a full refill and the counter at 0.
